fpu_normalize: RTL



---
 rtl/fpu_normalize.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fpu_normalize.sv
// rtl/fpu_normalize.sv - multi-cycle FP32 significand normalizer with valid/ready handshake
module fpu_normalize #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exponent,
    input  logic [23:0] in_significand,
    input  logic        in_is_zero,
    input  logic        in_is_inf,
    input  logic        in_is_nan,
    input  logic        in_is_snan,
    input  logic        in_is_subnormal,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [9:0]  out_exp,
    output logic [23:0] out_sig,
    output logic [4:0]  out_shift,
    output logic        out_is_zero,
    output logic        out_is_inf,
    output logic        out_is_nan,
    output logic        out_is_snan
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    localparam logic [9:0] EXP_SUBNORMAL = 10'h382;  // -126
    localparam logic [4:0] STEP_W        = 5'(STEP);

    state_t      state, state_next;
    logic [23:0] sig_reg;
    logic [9:0]  exp_reg;
    logic [4:0]  shift_reg;
    logic        sign_reg;
    logic [3:0]  flags_reg;

    logic [4:0]  lz;
    logic        found;
    logic [4:0]  k;
    logic [23:0] sig_shifted;
    logic [9:0]  exp_shifted;
    logic [4:0]  shift_sum;
    logic [9:0]  direct_exp;
    logic [23:0] direct_sig;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Leading-zero count of the working significand, clipped to STEP per cycle
    always_comb begin
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (sig_reg[i]) found = 1'b1;
                else            lz    = lz + 5'd1;
            end
        end
        k           = (lz > STEP_W) ? STEP_W : lz;
        sig_shifted = sig_reg << k;
        exp_shifted = exp_reg - {5'd0, k};
        shift_sum   = shift_reg + k;
    end

    always_comb begin
        direct_exp = {2'b00, in_exponent} - 10'd127;
        direct_sig = in_significand;
        if (in_is_zero) begin
            direct_exp = 10'd0;
            direct_sig = 24'd0;
        end else if (in_is_inf || in_is_nan) begin
            direct_exp = 10'd128;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = in_is_subnormal ? NORM : DONE;
            NORM: if (sig_shifted[23]) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sig_reg     <= 24'd0;
            exp_reg     <= 10'd0;
            shift_reg   <= 5'd0;
            sign_reg    <= 1'b0;
            flags_reg   <= 4'd0;
            out_sign    <= 1'b0;
            out_exp     <= 10'd0;
            out_sig     <= 24'd0;
            out_shift   <= 5'd0;
            out_is_zero <= 1'b0;
            out_is_inf  <= 1'b0;
            out_is_nan  <= 1'b0;
            out_is_snan <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_is_subnormal) begin
                            sig_reg   <= in_significand;
                            exp_reg   <= EXP_SUBNORMAL;
                            shift_reg <= 5'd0;
                            sign_reg  <= in_sign;
                            flags_reg <= {in_is_zero, in_is_inf, in_is_nan, in_is_snan};
                        end else begin
                            out_sign    <= in_sign;
                            out_exp     <= direct_exp;
                            out_sig     <= direct_sig;
                            out_shift   <= 5'd0;
                            out_is_zero <= in_is_zero;
                            out_is_inf  <= in_is_inf;
                            out_is_nan  <= in_is_nan;
                            out_is_snan <= in_is_snan;
                        end
                    end
                end
                NORM: begin
                    sig_reg   <= sig_shifted;
                    exp_reg   <= exp_shifted;
                    shift_reg <= shift_sum;
                    // Outputs only update on the edge that enters DONE
                    if (sig_shifted[23]) begin
                        out_sign    <= sign_reg;
                        out_exp     <= exp_shifted;
                        out_sig     <= sig_shifted;
                        out_shift   <= shift_sum;
                        out_is_zero <= flags_reg[3];
                        out_is_inf  <= flags_reg[2];
                        out_is_nan  <= flags_reg[1];
                        out_is_snan <= flags_reg[0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
